qspis_wb_arb: RTL and testbench

//   Two-master Wishbone arbiter that shares one WB slave bus.

---
 rtl/qspis_wb_arb.sv | 136 +++++++++++++
 tb/tb_qspis_wb_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspis_wb_arb.sv
// qspis_wb_arb: shares one Wishbone slave bus between two masters.
// Arbitration is round-robin, and the owner keeps the bus for its whole cyc.
// A watchdog ends a strobe that the slave never answers with an error.
module qspis_wb_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [1:0]          m_cyc_i,
  input  logic [1:0]          m_stb_i,
  input  logic [2*AW-1:0]     m_adr_i,
  input  logic [1:0]          m_we_i,
  input  logic [2*DW-1:0]     m_dat_i,
  input  logic [2*(DW/8)-1:0] m_sel_i,
  output logic [2*DW-1:0]     m_dat_o,
  output logic [1:0]          m_ack_o,
  output logic [1:0]          m_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic [AW-1:0]       s_adr_o,
  output logic                s_we_o,
  output logic [DW-1:0]       s_dat_o,
  output logic [DW/8-1:0]     s_sel_o,
  input  logic [DW-1:0]       s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  output logic [1:0]          gnt_o,
  output logic                timeout_o
);

  localparam int SW = DW / 8;
  localparam logic [15:0] TimeoutW = 16'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic        owner_q;
  logic        lastOwner_q;
  logic [15:0] wdog_q;
  logic [1:0]  gnt_q;

  logic busy;
  logic ownCyc;
  logic ownStb;
  logic wdogExpire;
  logic stbOut;
  logic cycOut;
  logic ackOne;
  logic errOne;
  logic grantSel;

  assign busy       = (state_q == BUSY);
  assign ownCyc     = m_cyc_i[owner_q];
  assign ownStb     = m_stb_i[owner_q] & ownCyc;
  assign wdogExpire = busy & ownStb & (wdog_q == TimeoutW);
  assign stbOut     = busy & ownStb & ~wdogExpire;
  assign cycOut     = busy & ownCyc & ~wdogExpire;
  assign ackOne     = s_ack_i & ~s_err_i & stbOut;
  assign errOne     = (s_err_i & stbOut) | wdogExpire;
  assign grantSel   = (&m_cyc_i) ? ~lastOwner_q : m_cyc_i[1];

  assign s_cyc_o    = cycOut;
  assign s_stb_o    = stbOut;
  assign timeout_o  = wdogExpire;
  assign gnt_o      = gnt_q;
  assign m_dat_o    = {2{s_dat_i}};

  // Route the owner's request onto the slave bus and its responses back; all zero while idle
  always_comb begin
    s_adr_o = '0;
    s_we_o  = 1'b0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = 2'b00;
    m_err_o = 2'b00;
    if (busy) begin
      if (owner_q) begin
        s_adr_o = m_adr_i[2*AW-1:AW];
        s_we_o  = m_we_i[1];
        s_dat_o = m_dat_i[2*DW-1:DW];
        s_sel_o = m_sel_i[2*SW-1:SW];
        m_ack_o = {ackOne, 1'b0};
        m_err_o = {errOne, 1'b0};
      end else begin
        s_adr_o = m_adr_i[AW-1:0];
        s_we_o  = m_we_i[0];
        s_dat_o = m_dat_i[DW-1:0];
        s_sel_o = m_sel_i[SW-1:0];
        m_ack_o = {1'b0, ackOne};
        m_err_o = {1'b0, errOne};
      end
    end
  end

  // Arbitration FSM: grant on request, release on cyc drop or watchdog expiry
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastOwner_q <= 1'b1;
      wdog_q      <= '0;
      gnt_q       <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          wdog_q <= '0;
          if (|m_cyc_i) begin
            state_q <= BUSY;
            owner_q <= grantSel;
            gnt_q   <= grantSel ? 2'b10 : 2'b01;
          end
        end
        BUSY: begin
          if (!ownCyc || wdogExpire) begin
            state_q     <= IDLE;
            lastOwner_q <= owner_q;
            gnt_q       <= 2'b00;
            wdog_q      <= '0;
          end else if (ownStb && !s_ack_i && !s_err_i) begin
            wdog_q <= wdog_q + 16'd1;
          end else begin
            wdog_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          wdog_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspis_wb_arb.sv
// tb_qspis_wb_arb: directed scenarios for the two-master Wishbone arbiter.
module tb_qspis_wb_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic                sys_clk;
  logic                rst_n;
  logic [1:0]          m_cyc_i;
  logic [1:0]          m_stb_i;
  logic [2*AW-1:0]     m_adr_i;
  logic [1:0]          m_we_i;
  logic [2*DW-1:0]     m_dat_i;
  logic [2*SW-1:0]     m_sel_i;
  logic [2*DW-1:0]     m_dat_o;
  logic [1:0]          m_ack_o;
  logic [1:0]          m_err_o;
  logic                s_cyc_o;
  logic                s_stb_o;
  logic [AW-1:0]       s_adr_o;
  logic                s_we_o;
  logic [DW-1:0]       s_dat_o;
  logic [SW-1:0]       s_sel_o;
  logic [DW-1:0]       s_dat_i;
  logic                s_ack_i;
  logic                s_err_i;
  logic [1:0]          gnt_o;
  logic                timeout_o;

  int checkCount;
  int errorCount;

  qspis_wb_arb #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_adr_i  (m_adr_i),
    .m_we_i   (m_we_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_adr_o  (s_adr_o),
    .s_we_o   (s_we_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .gnt_o    (gnt_o),
    .timeout_o(timeout_o)
  );

  // Free-running 10 ns system clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Advance to just after the next rising edge, where inputs are changed
  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  // Return every master and slave input to its quiet value
  task automatic applyIdle();
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    m_adr_i = '0;
    m_we_i  = 2'b00;
    m_dat_i = '0;
    m_sel_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
  endtask

  // Reset values of all outputs
  task automatic test_reset();
    rst_n = 1'b0;
    applyIdle();
    step();
    step();
    checkCount++;
    if (gnt_o !== 2'b00) begin errorCount++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt_o); end
    checkCount++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin errorCount++; $display("[TB] FAIL reset_sctl: got %b expected 000", {s_cyc_o, s_stb_o, s_we_o}); end
    checkCount++;
    if ({m_ack_o, m_err_o, timeout_o} !== 5'b0) begin errorCount++; $display("[TB] FAIL reset_resp: got %b expected 00000", {m_ack_o, m_err_o, timeout_o}); end
    checkCount++;
    if ({s_adr_o, s_dat_o, s_sel_o} !== '0) begin errorCount++; $display("[TB] FAIL reset_sbus: got %h expected 0", {s_adr_o, s_dat_o, s_sel_o}); end
    rst_n = 1'b1;
    step();
  endtask

  // m0 single read with a two-cycle slave latency
  task automatic test_read();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    m_adr_i[AW-1:0] = 32'h3000_0010;
    m_sel_i[SW-1:0] = 4'hF;
    #1;
    checkCount++;
    if (s_cyc_o !== 1'b0) begin errorCount++; $display("[TB] FAIL read_scyc_early: got %b expected 0", s_cyc_o); end
    step();
    checkCount++;
    if ({s_cyc_o, s_stb_o, gnt_o} !== 4'b1101) begin errorCount++; $display("[TB] FAIL read_grant: got %b expected 1101", {s_cyc_o, s_stb_o, gnt_o}); end
    checkCount++;
    if ({s_adr_o, s_we_o} !== {32'h3000_0010, 1'b0}) begin errorCount++; $display("[TB] FAIL read_adr: got %h/%b expected 30000010/0", s_adr_o, s_we_o); end
    step();
    checkCount++;
    if (m_ack_o !== 2'b00) begin errorCount++; $display("[TB] FAIL read_wait_ack: got %b expected 00", m_ack_o); end
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    #1;
    checkCount++;
    if (m_ack_o !== 2'b01) begin errorCount++; $display("[TB] FAIL read_ack: got %b expected 01", m_ack_o); end
    checkCount++;
    if (m_dat_o[DW-1:0] !== 32'hDEAD_BEEF) begin errorCount++; $display("[TB] FAIL read_data: got %h expected deadbeef", m_dat_o[DW-1:0]); end
    step();
    applyIdle();
    #1;
    checkCount++;
    if (s_cyc_o !== 1'b0) begin errorCount++; $display("[TB] FAIL read_drop: got %b expected 0", s_cyc_o); end
    step();
    checkCount++;
    if ({gnt_o, s_adr_o} !== '0) begin errorCount++; $display("[TB] FAIL read_idle: got %b/%h expected 00/0", gnt_o, s_adr_o); end
  endtask

  // Simultaneous requests after reset alternate between the masters
  task automatic test_round_robin();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    m_we_i  = 2'b11;
    m_adr_i = {32'h0000_0B00, 32'h0000_0A00};
    m_dat_i = {32'h2222_2222, 32'h1111_1111};
    m_sel_i = 8'hFF;
    step();
    s_ack_i = 1'b1;
    #1;
    checkCount++;
    if (gnt_o !== 2'b01) begin errorCount++; $display("[TB] FAIL rr_first: got %b expected 01", gnt_o); end
    checkCount++;
    if ({s_adr_o, s_dat_o, s_we_o} !== {32'h0000_0A00, 32'h1111_1111, 1'b1}) begin errorCount++; $display("[TB] FAIL rr_m0_bus: got %h/%h expected a00/11111111", s_adr_o, s_dat_o); end
    checkCount++;
    if (m_ack_o !== 2'b01) begin errorCount++; $display("[TB] FAIL rr_m0_ack: got %b expected 01", m_ack_o); end
    step();
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    s_ack_i = 1'b0;
    step();
    checkCount++;
    if (gnt_o !== 2'b00) begin errorCount++; $display("[TB] FAIL rr_gap: got %b expected 00", gnt_o); end
    step();
    s_ack_i = 1'b1;
    #1;
    checkCount++;
    if (gnt_o !== 2'b10) begin errorCount++; $display("[TB] FAIL rr_second: got %b expected 10", gnt_o); end
    checkCount++;
    if ({s_adr_o, s_dat_o} !== {32'h0000_0B00, 32'h2222_2222}) begin errorCount++; $display("[TB] FAIL rr_m1_bus: got %h/%h expected b00/22222222", s_adr_o, s_dat_o); end
    checkCount++;
    if (m_ack_o !== 2'b10) begin errorCount++; $display("[TB] FAIL rr_m1_ack: got %b expected 10", m_ack_o); end
    step();
    applyIdle();
    step();
    step();
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    step();
    checkCount++;
    if (gnt_o !== 2'b01) begin errorCount++; $display("[TB] FAIL rr_repeat: got %b expected 01", gnt_o); end
    applyIdle();
    step();
    step();
  endtask

  // m1 keeps the bus across four beats while m0 waits
  task automatic test_hold();
    m_cyc_i[1] = 1'b1;
    m_we_i[1]  = 1'b1;
    step();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    for (int beat = 0; beat < 4; beat++) begin
      m_stb_i[1] = 1'b1;
      m_dat_i[2*DW-1:DW] = 32'hB000_0000 + 32'(beat);
      s_ack_i = 1'b1;
      #1;
      checkCount++;
      if ({gnt_o, m_ack_o} !== 4'b1010) begin errorCount++; $display("[TB] FAIL hold_beat%0d: got gnt %b ack %b expected 10/10", beat, gnt_o, m_ack_o); end
      step();
      m_stb_i[1] = 1'b0;
      s_ack_i = 1'b0;
      #1;
      checkCount++;
      if ({gnt_o, m_ack_o} !== 4'b1000) begin errorCount++; $display("[TB] FAIL hold_gap%0d: got gnt %b ack %b expected 10/00", beat, gnt_o, m_ack_o); end
      step();
    end
    m_cyc_i[1] = 1'b0;
    #1;
    checkCount++;
    if ({s_cyc_o, m_ack_o} !== 3'b000) begin errorCount++; $display("[TB] FAIL hold_release: got %b expected 000", {s_cyc_o, m_ack_o}); end
    step();
    checkCount++;
    if (gnt_o !== 2'b00) begin errorCount++; $display("[TB] FAIL hold_gap_idle: got %b expected 00", gnt_o); end
    step();
    checkCount++;
    if (gnt_o !== 2'b01) begin errorCount++; $display("[TB] FAIL hold_m0_grant: got %b expected 01", gnt_o); end
    applyIdle();
    step();
    step();
  endtask

  // Unanswered m0 strobe is ended by the watchdog after 16 wait cycles
  task automatic test_timeout();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    step();
    for (int i = 1; i <= 16; i++) begin
      checkCount++;
      if ({s_stb_o, m_err_o, timeout_o} !== 4'b1000) begin errorCount++; $display("[TB] FAIL tmo_wait%0d: got %b expected 1000", i, {s_stb_o, m_err_o, timeout_o}); end
      step();
    end
    checkCount++;
    if ({m_err_o, timeout_o} !== 3'b011) begin errorCount++; $display("[TB] FAIL tmo_expire: got %b expected 011", {m_err_o, timeout_o}); end
    checkCount++;
    if ({s_cyc_o, s_stb_o} !== 2'b00) begin errorCount++; $display("[TB] FAIL tmo_force: got %b expected 00", {s_cyc_o, s_stb_o}); end
    step();
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    #1;
    checkCount++;
    if ({gnt_o, m_err_o, timeout_o, s_cyc_o} !== 6'b0) begin errorCount++; $display("[TB] FAIL tmo_idle: got %b expected 000000", {gnt_o, m_err_o, timeout_o, s_cyc_o}); end
    step();
  endtask

  // Simultaneous ack and err for m1 is reported as an error
  task automatic test_ack_err();
    m_cyc_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    step();
    s_ack_i = 1'b1;
    s_err_i = 1'b1;
    #1;
    checkCount++;
    if ({m_err_o, m_ack_o} !== 4'b1000) begin errorCount++; $display("[TB] FAIL ackerr: got err %b ack %b expected 10/00", m_err_o, m_ack_o); end
    step();
    applyIdle();
    step();
    step();
  endtask

  // Reset while m0 waits in BUSY drops ownership without a response
  task automatic test_reset_busy();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    step();
    checkCount++;
    if (gnt_o !== 2'b01) begin errorCount++; $display("[TB] FAIL rstb_pre: got %b expected 01", gnt_o); end
    rst_n = 1'b0;
    step();
    checkCount++;
    if ({gnt_o, s_cyc_o, m_err_o, m_ack_o} !== 7'b0) begin errorCount++; $display("[TB] FAIL rstb_drop: got %b expected 0000000", {gnt_o, s_cyc_o, m_err_o, m_ack_o}); end
    rst_n = 1'b1;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    step();
    checkCount++;
    if (gnt_o !== 2'b01) begin errorCount++; $display("[TB] FAIL rstb_regrant: got %b expected 01", gnt_o); end
    applyIdle();
    step();
  endtask

  // Run every scenario in order and report
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    applyIdle();
    test_reset();
    test_read();
    test_round_robin();
    test_hold();
    test_timeout();
    test_ack_err();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
